hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
//  Replaces single-cycle combinational MULT/DIV in EX: EX issues R-type HI/LO ops here.
//  The block iterates the ops over WIDTH cycles and raises Stall to the pipeline when a
//  HI/LO access or a new op collides with an op in flight.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each, product is 2*WIDTH
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  CLK      in   1      clock, all state on rising edge
//  RST      in   1      synchronous reset, active-low
//  Issue    in   1      EX presents a valid R-type op this cycle
//  Funct    in   6      Ins[5:0]: MULT 18h, MULTU 19h, DIV 1Ah, DIVU 1Bh, MFHI 10h, MTHI 11h, MFLO 12h, MTLO 13h
//  Rdata1   in   WIDTH  rs operand (multiplicand / dividend)
//  Rdata2   in   WIDTH  rt operand (multiplier / divisor / MTHI-MTLO source)
//  Busy     out  1      op in flight; HI/LO not yet valid
//  Stall    out  1      combinational: Issue && HI/LO funct && Busy
//  Done     out  1      one-cycle pulse on the cycle HI/LO take the final result
//  Hi       out  WIDTH  architectural HI
//  Lo       out  WIDTH  architectural LO
//  MfData   out  WIDTH  combinational: Hi for MFHI, Lo for MFLO, else 0
// BEHAVIOUR
//  Reset (RST==0 at edge): state IDLE, Hi=Lo=0, Busy=0, Done=0, counter=0. Applies mid-op; the op is discarded.
//  Accept: Issue && !Busy && Funct in {MULT,MULTU,DIV,DIVU}. Operands are latched that edge.
//    Non-HI/LO functs are ignored with no stall.
//  MTHI/MTLO when !Busy: Hi/Lo <= Rdata2 at the edge. No Busy, no Done.
//  MFHI/MFLO when !Busy: MfData is valid the same cycle.
//  Any HI/LO funct with Busy=1 gives Stall=1 and is not accepted. EX holds Issue and the
//    operands until Stall drops.
//  FSM: IDLE -> MUL | DIV on accept; MUL/DIV -> FIX after WIDTH iterations; FIX -> IDLE.
//    DIV -> FIX directly on divide-by-zero.
//  Busy=1 in MUL, DIV and FIX. Done=1 in the cycle after FIX, with Busy=0 and Hi/Lo updated.
//    Result latency: Done rises WIDTH+2 cycles after the accept edge (34 for WIDTH=32).
//    An Issue in the FIX cycle stalls. It is accepted in the Done cycle (back-to-back).
//  Signed ops (MULT, DIV): latch |rs| and |rt|, record the signs, iterate unsigned, apply
//    two's-complement negation in FIX.
//  MUL: shift-add, 1 bit/cycle. {Hi,Lo} = full 2*WIDTH product. MULT is signed, MULTU unsigned.
//  DIV: restoring, 1 quotient bit/cycle. Lo = quotient, Hi = remainder.
//    Signed quotient truncates toward zero; remainder takes the dividend's sign.
//  DIV 80000000h / FFFFFFFFh: Lo = 80000000h, Hi = 0. No trap.
//  Divide by zero (rt==0): Lo = FFFFFFFFh, Hi = rs unmodified, signed or unsigned.
//    Done 2 cycles after accept.
//  Internal widths: remainder accumulator WIDTH+1 bits; product accumulator 2*WIDTH+1 bits
//    to hold the carry. No truncation before FIX.
// STRUCTURE
//  Funct codes come from the shared common_param.vh. Add there:
//    FSM state localparams (IDLE, MUL, DIV, FIX) and the HI/LO-funct membership function.
//  One sub-module is natural: muldiv_iter_dp.
//    It holds the accumulator, shift register and counter, and performs one add/sub-shift per enable.
//  This block keeps the FSM, sign fixup, Hi/Lo registers, Stall/MfData logic.
// TESTING
//  MULTU 0000FFFFh*0001_0000h -> Done at +34, Hi=0, Lo=FFFF0000h; Busy high for 33 cycles.
//  MULT FFFFFFFEh(-2)*00000003h -> Hi=FFFFFFFFh, Lo=FFFFFFFAh; MULTU same operands -> Hi=2, Lo=FFFFFFFAh.
//  DIV FFFFFFF9h(-7)/2 -> Lo=FFFFFFFDh(-3), Hi=FFFFFFFFh(-1); DIV 80000000h/FFFFFFFFh -> Lo=80000000h, Hi=0.
//  DIVU 12345678h/0 -> Done at +2, Lo=FFFFFFFFh, Hi=12345678h.
//  Hazard: MFLO issued 1 cycle after MULT -> Stall=1 each cycle until the Done cycle,
//    then MfData=Lo. MTHI while Busy stalls; Hi is unchanged until accepted.
//  RST=0 at cycle 10 of a DIVU -> next cycle Busy=0, Hi=Lo=0, no Done. A MULTU issued next proceeds normally.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared funct codes, sequencer states and decode helpers for the
// HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return is_muldiv(f) ||
      (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return f inside {F_MULT, F_DIV};
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return f inside {F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter_dp.sv
// Iterative datapath: one shift-add (multiply) or one restoring
// subtract-shift (divide) step per enable, plus the iteration counter.
module hilo_muldiv_ctrl_iter_dp #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               last
);

  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_nxt;
  logic [WIDTH-1:0] opb;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  // Low half starts as multiplier / dividend and shifts out as
  // the product low word / quotient shifts in.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
        + (acc[0] ? {1'b0, opb} : '0);
    shifted = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    diff = shifted - {2'b00, opb};
    ge = ~diff[WIDTH+1];
    if (div_mode) begin
      acc_nxt = {ge ? diff[WIDTH:0] : shifted[WIDTH:0],
                 acc[WIDTH-2:0], ge};
    end else begin
      acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {{(WIDTH+1){1'b0}}, a};
      opb <= b;
      cnt <= '0;
    end else if (en) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign res  = acc[2*WIDTH-1:0];
  assign last = (cnt == CNT_W'(WIDTH-1));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences multi-cycle MULT/DIV, applies sign fixup,
// and stalls EX on HI/LO accesses that collide with an op in flight.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Issue,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] MfData
);

  state_t state, nxt;

  logic               accept, idle_issue;
  logic               neg_a, neg_b, last;
  logic               sa, sb, dz, op_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   q, r, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] res, prod;

  assign Busy       = (state != IDLE);
  assign Stall      = Issue && is_hilo(Funct) && Busy;
  assign idle_issue = Issue && !Busy;
  assign accept     = idle_issue && is_muldiv(Funct);

  assign neg_a = is_signed_op(Funct) && Rdata1[WIDTH-1];
  assign neg_b = is_signed_op(Funct) && Rdata2[WIDTH-1];
  assign abs_a = neg_a ? -Rdata1 : Rdata1;
  assign abs_b = neg_b ? -Rdata2 : Rdata2;

  hilo_muldiv_ctrl_iter_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .en       (state == MUL || state == DIV),
    .div_mode (state == DIV),
    .a        (abs_a),
    .b        (abs_b),
    .res      (res),
    .last     (last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (!is_div_op(Funct)) nxt = MUL;
        else if (Rdata2 == '0) nxt = FIX;
        else nxt = DIV;
      end
      MUL, DIV: if (last) nxt = FIX;
      FIX: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Divide-by-zero skips iteration, so q still holds |rs|.
  always_comb begin
    q    = res[WIDTH-1:0];
    r    = res[2*WIDTH-1:WIDTH];
    prod = (sa ^ sb) ? -res : res;
    if (op_div) begin
      fix_lo = dz ? '1 : ((sa ^ sb) ? -q : q);
      fix_hi = dz ? (sa ? -q : q) : (sa ? -r : r);
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    unique case (1'b1)
      Funct == F_MFHI: MfData = Hi;
      Funct == F_MFLO: MfData = Lo;
      default:         MfData = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      Hi     <= '0;
      Lo     <= '0;
      Done   <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      op_div <= 1'b0;
    end else begin
      state <= nxt;
      Done  <= (state == FIX);
      if (accept) begin
        sa     <= neg_a;
        sb     <= neg_b;
        dz     <= (Rdata2 == '0);
        op_div <= is_div_op(Funct);
      end
      if (state == FIX) begin
        Hi <= fix_hi;
        Lo <= fix_lo;
      end else if (idle_issue && Funct == F_MTHI) begin
        Hi <= Rdata2;
      end else if (idle_issue && Funct == F_MTLO) begin
        Lo <= Rdata2;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: arithmetic reference model with
// per-cycle compare plus directed literal expectations.
module tb_hilo_muldiv_ctrl;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] ADD   = 6'h20;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Issue = 1'b0;
  logic [5:0]  Funct = '0;
  logic [31:0] Rdata1 = '0;
  logic [31:0] Rdata2 = '0;
  logic        Busy, Stall, Done;
  logic [31:0] Hi, Lo, MfData;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  hilo_muldiv_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .Issue  (Issue),
    .Funct  (Funct),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2),
    .Busy   (Busy),
    .Stall  (Stall),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo),
    .MfData (MfData)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hilo_f(input logic [5:0] f);
    return f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  // Returns {HI, LO} for a mul/div op from plain integer arithmetic.
  function automatic logic [63:0] model_op(input logic [5:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint x, y;
    logic [63:0] qq, rr;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (f)
      MULT:  return 64'(x * y);
      MULTU: return {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        qq = 64'(x / y);
        rr = 64'(x % y);
        return {rr[31:0], qq[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge CLK) begin
    logic [63:0] hl;
    if (!RST) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (Issue) begin
        if (Funct inside {MULT, MULTU, DIV, DIVU}) begin
          hl = model_op(Funct, Rdata1, Rdata2);
          p_hi <= hl[63:32];
          p_lo <= hl[31:0];
          m_left <= ((Funct inside {DIV, DIVU}) && Rdata2 == '0) ? 1 : 33;
        end else if (Funct == MTHI) begin
          m_hi <= Rdata2;
        end else if (Funct == MTLO) begin
          m_lo <= Rdata2;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 32'(Busy), 32'(m_left > 0));
      chk("done", 32'(Done), 32'(m_done));
      chk("hi", Hi, m_hi);
      chk("lo", Lo, m_lo);
      chk("stall", 32'(Stall), 32'(Issue && hilo_f(Funct) && m_left > 0));
      chk("mfdata", MfData,
          (Funct == MFHI) ? m_hi : (Funct == MFLO) ? m_lo : 32'h0);
    end
  end

  task automatic drive(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    Issue = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
  endtask

  task automatic idle_in();
    Issue = 1'b0; Funct = '0; Rdata1 = '0; Rdata2 = '0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      lat++;
      if (Busy) bc++;
      if (Done) return;
    end
    chk("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic run(input string nm, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] eh,
                     input logic [31:0] el);
    int lat, bc;
    @(posedge CLK); #2;
    drive(f, a, b);
    @(posedge CLK); #2;
    idle_in();
    wait_done(lat, bc);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_busycyc"}, 32'(bc), 32'(exp_lat - 1));
    chk({nm, "_hi"}, Hi, eh);
    chk({nm, "_lo"}, Lo, el);
    chk({nm, "_mhi"}, m_hi, eh);
    chk({nm, "_mlo"}, m_lo, el);
  endtask

  initial begin
    int lat;
    bit seen, got1;
    @(posedge CLK);
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b1;

    run("multu_a", MULTU, 32'h0000_FFFF, 32'h0001_0000, 34, 32'h0, 32'hFFFF_0000);
    run("mult_neg", MULT, 32'hFFFF_FFFE, 32'h3, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu_b", MULTU, 32'hFFFF_FFFE, 32'h3, 34, 32'h2, 32'hFFFF_FFFA);
    run("div_neg", DIV, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
    run("divu_z", DIVU, 32'h1234_5678, 32'h0, 2, 32'h1234_5678, 32'hFFFF_FFFF);
    run("div_z", DIV, 32'hFFFF_FFF9, 32'h0, 2, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("divu_a", DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);

    // MFLO one cycle behind MULT stalls until the Done cycle.
    @(posedge CLK); #2;
    drive(MULT, 32'd7, 32'd5);
    @(posedge CLK); #2;
    drive(MFLO, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (Done) begin
        chk("haz_stall_done", 32'(Stall), 32'd0);
        chk("haz_mf", MfData, 32'd35);
        seen = 1'b1;
        break;
      end
      chk("haz_stall", 32'(Stall), 32'd1);
    end
    if (!seen) chk("haz_timeout", 32'd0, 32'd1);
    @(posedge CLK); #2;
    idle_in();

    // MTHI during an op waits, then lands after the result.
    @(posedge CLK); #2;
    drive(MULTU, 32'd2, 32'd3);
    @(posedge CLK); #2;
    drive(MTHI, 32'h0, 32'hAAAA_5555);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (Done) begin
        chk("mthi_res_hi", Hi, 32'h0);
        chk("mthi_res_lo", Lo, 32'd6);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("mthi_timeout", 32'd0, 32'd1);
    @(posedge CLK); #2;
    idle_in();
    @(negedge CLK);
    chk("mthi_hi", Hi, 32'hAAAA_5555);

    @(posedge CLK); #2;
    drive(MTLO, 32'h0, 32'h1357_9BDF);
    @(posedge CLK); #2;
    drive(MFLO, 32'h0, 32'h0);
    @(negedge CLK);
    chk("mflo_idle", MfData, 32'h1357_9BDF);
    chk("mflo_nostall", 32'(Stall), 32'd0);
    @(posedge CLK); #2;
    drive(MFHI, 32'h0, 32'h0);
    @(negedge CLK);
    chk("mfhi_idle", MfData, 32'hAAAA_5555);
    chk("mfhi_busy", 32'(Busy), 32'd0);

    // Back-to-back: second op held from accept, taken in Done cycle.
    @(posedge CLK); #2;
    drive(MULTU, 32'd3, 32'd4);
    @(posedge CLK); #2;
    drive(ADD, 32'd1, 32'd2);
    @(negedge CLK);
    chk("nonhilo_stall", 32'(Stall), 32'd0);
    lat = 1;
    @(posedge CLK); #2;
    drive(MULTU, 32'd5, 32'd6);
    got1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      lat++;
      if (Done && !got1) begin
        got1 = 1'b1;
        chk("b2b_lat1", 32'(lat), 32'd34);
        chk("b2b_lo1", Lo, 32'd12);
        @(posedge CLK); #2;
        idle_in();
      end else if (Done) begin
        chk("b2b_lat2", 32'(lat), 32'd68);
        chk("b2b_lo2", Lo, 32'd30);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("b2b_timeout", 32'd0, 32'd1);

    // Reset in the middle of a DIVU discards it.
    @(posedge CLK); #2;
    drive(DIVU, 32'd100, 32'd7);
    @(posedge CLK); #2;
    idle_in();
    repeat (9) @(posedge CLK);
    #2;
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_busy_pre", 32'(Busy), 32'd1);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_hi", Hi, 32'd0);
    chk("midrst_lo", Lo, 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    @(negedge CLK);
    chk("midrst_done2", 32'(Done), 32'd0);
    run("post_rst", MULTU, 32'd6, 32'd7, 34, 32'd0, 32'd42);

    repeat (3) @(posedge CLK);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
